// File: rtl/hawk_cpu_rd_req_buf.sv
// ------------------------------------------------------------------------
// hawk_cpu_rd_req_buf: in-order AR queue with outstanding-read limiting
// and next-page lookahead for the hawk read stall stage.   Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 4
`endif

module hawk_cpu_rd_req_buf #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_WIDTH        = `HACD_AXI4_ID_WIDTH,
  parameter int ADDR_WIDTH      = `HACD_AXI4_ADDR_WIDTH,
  parameter int USER_WIDTH      = `HACD_AXI4_USER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ID_WIDTH-1:0]      s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic [USER_WIDTH-1:0]    s_axi_aruser,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [ID_WIDTH-1:0]      m_axi_arid,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic [USER_WIDTH-1:0]    m_axi_aruser,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic                     r_mon_valid,
  input  logic                     r_mon_ready,
  input  logic                     r_mon_last,
  output logic                     lookahead_valid,
  output logic [ADDR_WIDTH-13:0]   lookahead_hppa,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               outstanding,
  output logic                     err_underflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + USER_WIDTH;
  localparam int ADDR_LO = 8 + 3 + 2 + USER_WIDTH;

  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_TWO  = OCC_W'(2);
  localparam logic [7:0]       MAX_OUT  = 8'(MAX_OUTSTANDING);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] next_entry;
  logic               enq;
  logic               deq;
  logic               r_done;

  // Both ready and valid derive only from registered state, so no input
  // can combinationally reach an output.
  assign s_axi_arready   = (occupancy != FULL_CNT);
  assign m_axi_arvalid   = (occupancy != '0) && (outstanding < MAX_OUT);
  assign lookahead_valid = (occupancy >= OCC_TWO);

  assign enq    = s_axi_arvalid && s_axi_arready;
  assign deq    = m_axi_arvalid && m_axi_arready;
  assign r_done = r_mon_valid && r_mon_ready && r_mon_last;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign head_entry = mem[rd_ptr];
  assign next_entry = mem[rd_ptr_nxt];

  assign {m_axi_arid, m_axi_araddr, m_axi_arlen,
          m_axi_arsize, m_axi_arburst, m_axi_aruser} = head_entry;
  assign lookahead_hppa = next_entry[ADDR_LO+ADDR_WIDTH-1:ADDR_LO+12];

  // Payload storage carries no reset; validity is tracked by occupancy.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= {s_axi_arid, s_axi_araddr, s_axi_arlen,
                      s_axi_arsize, s_axi_arburst, s_axi_aruser};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr_nxt;
      if (enq && !deq)      occupancy <= occupancy + OCC_W'(1);
      else if (deq && !enq) occupancy <= occupancy - OCC_W'(1);
    end
  end

  // A burst completion with nothing in flight saturates at zero and flags it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (deq && !r_done) begin
        outstanding <= outstanding + 8'd1;
      end else if (r_done && !deq) begin
        if (outstanding == 8'd0) err_underflow <= 1'b1;
        else                     outstanding   <= outstanding - 8'd1;
      end
    end
  end

endmodule

`default_nettype wire
